// File: rtl/imm_gen_stage.sv
// ID/EX immediate path: decodes the ImmSel immediate from the instruction word
// and holds it with its PC in a 2-entry valid/ready skid buffer.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_imm_sel,
    output logic            out_illegal
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_NONE = 3'b000;
    localparam logic [SEL_W-1:0] SEL_I    = 3'b001;
    localparam logic [SEL_W-1:0] SEL_S    = 3'b010;
    localparam logic [SEL_W-1:0] SEL_B    = 3'b011;
    localparam logic [SEL_W-1:0] SEL_J    = 3'b100;
    localparam logic [SEL_W-1:0] SEL_U    = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [SEL_W-1:0] sel;
        logic             illegal;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             new_entry;
    entry_t             head;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push;
    logic               pop;
    logic [XLEN-1:0]    imm_c;
    logic               illegal_c;
    logic               unused_opcode;

    // The opcode field carries no immediate bits.
    assign unused_opcode = &{1'b0, in_instr[6:0]};

    // Immediate decode from the incoming instruction word.
    always_comb begin
        imm_c     = '0;
        illegal_c = 1'b0;
        case (in_imm_sel)
            SEL_NONE: imm_c = '0;
            SEL_I:    imm_c = {{20{in_instr[31]}}, in_instr[31:20]};
            SEL_S:    imm_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_B:    imm_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_J:    imm_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            SEL_U:    imm_c = {in_instr[31:12], 12'b0};
            default:  illegal_c = 1'b1;
        endcase
    end

    always_comb begin
        new_entry         = '0;
        new_entry.imm     = imm_c;
        new_entry.pc      = in_pc;
        new_entry.sel     = in_imm_sel;
        new_entry.illegal = illegal_c;
    end

    // Handshake status depends only on registered occupancy.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Reset clears contents too; flush only drops occupancy and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Head fields are forced to zero whenever the buffer is empty.
    assign head        = out_valid ? mem[rd_ptr] : '0;
    assign out_imm     = head.imm;
    assign out_pc      = head.pc;
    assign out_imm_sel = head.sel;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: immediate formats, backpressure, flush and reset.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [2:0]  in_imm_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [2:0]  out_imm_sel;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    imm_gen_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_imm_sel  (in_imm_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_imm_sel (out_imm_sel),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [2:0] sel);
        in_valid   = v;
        in_instr   = instr;
        in_pc      = pc;
        in_imm_sel = sel;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] imm, input logic [31:0] pc,
                            input logic [2:0] sel, input logic ill);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_sel"}, 32'(out_imm_sel), 32'(sel));
        chk({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_imm"}, out_imm, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_sel"}, 32'(out_imm_sel), 32'd0);
        chk({tag, "_ill"}, 32'(out_illegal), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] instrs [4];
        logic [2:0]  sels   [4];
        logic [31:0] imms   [4];

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        step();
        step();
        chk_empty("reset");
        rst = 1'b0;

        // 1: addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h100, 3'b001);
        step();
        chk_head("t1", 32'hFFFFFFFF, 32'h100, 3'b001, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        step();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // 2: back-to-back S/B/J/U
        instrs[0] = 32'h0020A423; sels[0] = 3'b010; imms[0] = 32'h00000008;
        instrs[1] = 32'hFE000EE3; sels[1] = 3'b011; imms[1] = 32'hFFFFFFFC;
        instrs[2] = 32'h001000EF; sels[2] = 3'b100; imms[2] = 32'h00000800;
        instrs[3] = 32'h12345297; sels[3] = 3'b101; imms[3] = 32'h12345000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, instrs[k], 32'h200 + 32'(4 * k), sels[k]);
            chk($sformatf("t2_rdy%0d", k), 32'(in_ready), 32'd1);
            step();
            chk_head($sformatf("t2_%0d", k), imms[k], 32'h200 + 32'(4 * k), sels[k], 1'b0);
        end
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        step();
        chk("t2_drain", 32'(out_valid), 32'd0);

        // 3: backpressure, third push held upstream
        out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h0, 3'b001);
        step();
        chk("t3_rdy1", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h00000013, 32'h4, 3'b001);
        step();
        chk("t3_rdy2", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h00000013, 32'h8, 3'b001);
        step();
        chk("t3_hold_rdy", 32'(in_ready), 32'd0);
        chk("t3_hold_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        chk("t3_pc4", out_pc, 32'h4);
        chk("t3_rdy3", 32'(in_ready), 32'd1);
        step();
        chk_head("t3_pc8", 32'h0, 32'h8, 3'b001, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        step();
        chk("t3_drain", 32'(out_valid), 32'd0);

        // 4: illegal and none selections
        drive(1'b1, 32'hFFFFFFFF, 32'h300, 3'b110);
        step();
        chk_head("t4_ill", 32'h0, 32'h300, 3'b110, 1'b1);
        drive(1'b1, 32'hFFFFFFFF, 32'h304, 3'b000);
        step();
        chk_head("t4_none", 32'h0, 32'h304, 3'b000, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        step();

        // 5: flush while full with in_valid high
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h20, 3'b001);
        step();
        drive(1'b1, 32'hFFF00093, 32'h24, 3'b001);
        step();
        chk("t5_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h12345297, 32'h28, 3'b101);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_empty("t5_flush");
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        out_ready = 1'b1;
        step();
        chk("t5_gone", 32'(out_valid), 32'd0);

        // 6: reset at count 1 with push and pop in flight
        out_ready = 1'b0;
        drive(1'b1, 32'h0020A423, 32'h40, 3'b010);
        step();
        chk("t6_cnt1", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'hFE000EE3, 32'h44, 3'b011);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_empty("t6_rst");
        drive(1'b1, 32'hFFF00093, 32'h100, 3'b001);
        step();
        chk_head("t6_after", 32'hFFFFFFFF, 32'h100, 3'b001, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 3'b000);
        step();
        chk("t6_drain", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Consumer end of the decode ImmSel interface. Takes the instruction word, PC and 3-bit ImmSel from the decode stage and builds the sign-extended 32-bit immediate. Buffers the result in a 2-entry valid/ready skid buffer that acts as the ID/EX immediate path of the pipelined core. Supports stall through backpressure and flush on a branch or jump redirect.

Parameters:
XLEN, 32, datapath width of instr, PC and immediate. Only 32 is supported.
DEPTH, 2, buffer entries. Fixed at 2; other values are not supported.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous pipeline flush, same effect on the buffer as rst
in_valid  input  1  upstream entry valid
in_ready  output  1  block can accept an entry this cycle
in_instr  input  32  instruction word
in_pc  input  32  instruction PC
in_imm_sel  input  3  ImmSel from decode: 000 none, 001 I, 010 S, 011 B, 100 J, 101 U, 110/111 illegal
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head
out_imm  output  32  immediate of head entry
out_pc  output  32  PC of head entry
out_imm_sel  output  3  ImmSel of head entry
out_illegal  output  1  head entry carried ImmSel 110 or 111

Behaviour:
- Immediate is formed combinationally from in_instr at push time and stored; the buffer holds imm, pc, sel and illegal per entry.
- Immediate formats (i = in_instr):
  - I: 20 copies of i[31], then i[31:20].
  - S: 20 copies of i[31], then i[31:25], i[11:7].
  - B: 19 copies of i[31], then i[31], i[7], i[30:25], i[11:8], 0.
  - J: 11 copies of i[31], then i[31], i[19:12], i[20], i[30:21], 0.
  - U: i[31:12], then 12 zeros.
- Sel 000: imm 0, illegal 0. Sel 110/111: imm 0, illegal 1.
- Upstream must drive 000 (not X) for instructions with no immediate. X on in_imm_sel is illegal stimulus.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count < 2). It is a function of registered count only and must not depend on out_ready.
- out_valid = (count != 0).
- Output fields come from the head entry. All out_* fields are 0 while out_valid is 0.
- Latency: an entry pushed at edge N is at the output (out_valid=1) from N+1. No combinational path from in_* to out_*.
- Count and pointers:
  - count is 2 bits, range 0..2.
  - Push only: count+1. Pop only: count-1. Push and pop in the same cycle (count 1): count unchanged, FIFO order kept.
  - Count 2: in_ready=0, no push. A pop at count 2 gives in_ready=1 in the next cycle.
  - Read/write pointers are 1 bit and wrap modulo 2.
- Count 0 with in_valid=1 and out_ready=1: the push is accepted; pop is impossible (out_valid=0). Data appears the next cycle.
- flush=1 at an edge:
  - count, pointers and all out_* return to 0.
  - Any push or pop in that cycle is discarded.
  - in_ready is 1 in the next cycle.
  - flush has priority over push and pop.
- rst=1 at an edge: same as flush, and stored entry contents are zeroed.
  - Reset values: out_valid 0, out_imm 0, out_pc 0, out_imm_sel 000, out_illegal 0, in_ready 1.
  - Reset mid-transfer drops all entries; no partial entry survives.
- rst and flush together: rst effect (identical observable result).
- The block never stalls with out_ready held at 1 and never reorders entries.

Test Plan:
1. Reset, then push in_instr 0xFFF00093 (addi x1,x0,-1), sel 001, pc 0x100, out_ready=1 -> next cycle out_valid=1, out_imm 0xFFFFFFFF, out_pc 0x100, out_illegal 0.
2. Back-to-back pushes, one per cycle, out_ready=1:
   - sw 0x0020A423 sel 010 -> out_imm 0x00000008
   - beq 0xFE000EE3 sel 011 -> out_imm 0xFFFFFFFC
   - jal 0x001000EF sel 100 -> out_imm 0x00000800
   - auipc 0x12345297 sel 101 -> out_imm 0x12345000
   Each result arrives one cycle after its push, in order, with no in_ready drop.
3. out_ready=0, push 3 entries (pc 0x0, 0x4, 0x8) -> in_ready goes 0 after the second push and the third is held upstream. Raise out_ready -> PCs 0x0, 0x4, 0x8 emerge in order with no loss or duplication.
4. Push sel 110 and sel 000 with in_instr 0xFFFFFFFF -> sel 110: out_imm 0, out_illegal 1. Sel 000: out_imm 0, out_illegal 0.
5. Buffer full (count 2), assert flush together with in_valid=1 -> next cycle out_valid 0, in_ready 1. The flushed-cycle entry never appears.
6. Assert rst while count=1 and a push/pop is in progress -> all outputs 0 the next cycle. Entries pushed after reset release behave as in test 1.
